// File: rtl/memvec_seq_if.sv
// Command, byte-stream and memory-control bundle between the engine control and memvec_seq.
// master = engine/memory side, slave = the sequencer.
interface memvec_seq_if #(
  parameter int unsigned ROWS = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [7:0]      cmd_base;
  logic [8:0]      cmd_len;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            out_valid;
  logic [7:0]      out_data;
  logic            busy;
  logic            done;
  logic            mem_en;
  logic [7:0]      mem_din;
  logic [7:0]      mem_col;
  logic [ROWS-1:0] mem_rwl;
  logic [ROWS-1:0] mem_wwl;
  logic            mem_read;
  logic            mem_write;
  logic            mem_clr;
  logic [7:0]      mem_dout;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_len, in_valid, in_data, mem_dout,
    input  cmd_ready, in_ready, out_valid, out_data, busy, done, mem_en, mem_din, mem_col,
           mem_rwl, mem_wwl, mem_read, mem_write, mem_clr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_len, in_valid, in_data, mem_dout,
    output cmd_ready, in_ready, out_valid, out_data, busy, done, mem_en, mem_din, mem_col,
           mem_rwl, mem_wwl, mem_read, mem_write, mem_clr
  );
endinterface

// File: rtl/memvec_seq.sv
// Command sequencer for the conv-engine vector memory: CLEAR, column LOAD/DUMP and
// row-by-row ACCUM through the external adder. All memory controls are registered.
module memvec_seq #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned ADDER_LAT = 1,
  parameter int unsigned READ_LAT  = 1
) (
  input logic         clk,
  input logic         rst_n,
  memvec_seq_if.slave bus
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    StIdle, StClr, StLoad, StDump, StAccRd, StAccWait, StAccWr, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          base_q, base_d;
  logic [8:0]          len_q, len_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [8:0]          ocnt_q, ocnt_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [READ_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic                mem_en_q, mem_en_d;
  logic [7:0]          mem_din_q, mem_din_d;
  logic [7:0]          mem_col_q, mem_col_d;
  logic [ROWS-1:0]     mem_rwl_q, mem_rwl_d;
  logic [ROWS-1:0]     mem_wwl_q, mem_wwl_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_clr_q, mem_clr_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_data_q, out_data_d;
  logic                data_now;

  // High in the cycle mem_dout holds the byte for a read issued READ_LAT cycles ago.
  assign data_now = rd_pipe_q[READ_LAT-1];

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ocnt_d      = ocnt_q;
    row_d       = row_q;
    wcnt_d      = wcnt_q;
    rd_pipe_d   = (rd_pipe_q << 1) | READ_LAT'(mem_read_q);
    mem_en_d    = 1'b0;
    mem_din_d   = 8'h00;
    mem_col_d   = 8'h00;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    out_valid_d = data_now && (state_q == StDump);
    out_data_d  = (data_now && (state_q == StDump)) ? bus.mem_dout : 8'h00;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          base_d = bus.cmd_base;
          len_d  = bus.cmd_len;
          cnt_d  = '0;
          ocnt_d = '0;
          row_d  = '0;
          wcnt_d = '0;
          unique case (bus.cmd_op)
            2'b00:   state_d = StClr;
            2'b01:   state_d = (bus.cmd_len == 9'd0) ? StDone : StLoad;
            2'b10:   state_d = StAccRd;
            default: state_d = (bus.cmd_len == 9'd0) ? StDone : StDump;
          endcase
        end
      end
      StClr: state_d = StDone;
      StLoad: begin
        if (bus.in_valid) begin
          mem_en_d    = 1'b1;
          mem_write_d = 1'b1;
          mem_col_d   = base_q + cnt_q[7:0];
          mem_din_d   = bus.in_data;
          cnt_d       = cnt_q + 9'd1;
          if (cnt_q == len_q - 9'd1) state_d = StDone;
        end
      end
      StDump: begin
        if (cnt_q < len_q) begin
          mem_en_d   = 1'b1;
          mem_read_d = 1'b1;
          mem_col_d  = base_q + cnt_q[7:0];
          cnt_d      = cnt_q + 9'd1;
        end
        if (data_now) begin
          ocnt_d = ocnt_q + 9'd1;
          if (ocnt_q == len_q - 9'd1) state_d = StDone;
        end
      end
      StAccRd: begin
        wcnt_d  = '0;
        state_d = StAccWait;
      end
      StAccWait: begin
        if (wcnt_q == 4'(ADDER_LAT - 1)) state_d = StAccWr;
        else wcnt_d = wcnt_q + 4'd1;
      end
      StAccWr: begin
        if (row_q == RowW'(ROWS - 1)) begin
          state_d = StDone;
        end else begin
          row_d   = row_q + RowW'(1);
          state_d = StAccRd;
        end
      end
      default: state_d = StIdle;
    endcase

    // Wordline and clear strobes line up with the state they belong to.
    mem_clr_d = (state_d == StClr);
    mem_rwl_d = (state_d == StAccRd) ? (ROWS'(1) << row_d) : '0;
    mem_wwl_d = (state_d == StAccWr) ? (ROWS'(1) << row_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ocnt_q      <= '0;
      row_q       <= '0;
      wcnt_q      <= '0;
      rd_pipe_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_din_q   <= '0;
      mem_col_q   <= '0;
      mem_rwl_q   <= '0;
      mem_wwl_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ocnt_q      <= ocnt_d;
      row_q       <= row_d;
      wcnt_q      <= wcnt_d;
      rd_pipe_q   <= rd_pipe_d;
      mem_en_q    <= mem_en_d;
      mem_din_q   <= mem_din_d;
      mem_col_q   <= mem_col_d;
      mem_rwl_q   <= mem_rwl_d;
      mem_wwl_q   <= mem_wwl_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_clr_q   <= mem_clr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.in_ready  = (state_q == StLoad);
  assign bus.done      = (state_q == StDone);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_col   = mem_col_q;
  assign bus.mem_rwl   = mem_rwl_q;
  assign bus.mem_wwl   = mem_wwl_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_clr   = mem_clr_q;

endmodule

// File: tb/tb_memvec_seq.sv
// Bench for memvec_seq: vector table, directed corner sequences and random commands,
// checked against a 256-byte reference memory and timing rules derived from the command set.
module tb_memvec_seq;

  localparam int ROWS = 8;
  localparam int AL   = 1;
  localparam int RL   = 1;
  localparam logic [1:0] OpClr  = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpAcc  = 2'b10;
  localparam logic [1:0] OpDump = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memvec_seq_if #(.ROWS(ROWS)) bus ();

  memvec_seq #(.ROWS(ROWS), .ADDER_LAT(AL), .READ_LAT(RL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int n_rd = 0, n_clr = 0, n_done = 0;
  int first_rd = -1, clr_cyc = 0, done_cyc = 0;
  logic [7:0] wr_col_q[$], wr_din_q[$], out_q[$], load_bytes[$];
  int out_cyc_q[$], acc_cyc_q[$], acc_rwl_q[$], acc_wwl_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] mem_model [256];
  logic [7:0] rd_pipe [RL];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Byte-wide memory with READ_LAT-cycle read pipe; row selection is not modelled.
  always @(posedge clk) begin
    if (bus.mem_clr) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= 8'h00;
    end else if (bus.mem_write) begin
      mem_model[bus.mem_col] <= bus.mem_din;
    end
    rd_pipe[0] <= mem_model[bus.mem_col];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_dout = rd_pipe[RL-1];

  always @(negedge clk) begin
    int act;
    if (rst_n) begin
      act = int'(bus.mem_read) + int'(bus.mem_write) + int'(bus.mem_clr) +
            int'(|bus.mem_rwl) + int'(|bus.mem_wwl);
      chk("mem_strobe_exclusive", int'(act <= 1), 1);
      if (bus.mem_write) begin
        wr_col_q.push_back(bus.mem_col);
        wr_din_q.push_back(bus.mem_din);
      end
      if (bus.mem_read) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.mem_clr) begin
        n_clr++;
        clr_cyc = cyc;
      end
      if ((|bus.mem_rwl) || (|bus.mem_wwl)) begin
        acc_cyc_q.push_back(cyc);
        acc_rwl_q.push_back(int'(bus.mem_rwl));
        acc_wwl_q.push_back(int'(bus.mem_wwl));
      end
      if (bus.out_valid) begin
        out_q.push_back(bus.out_data);
        out_cyc_q.push_back(cyc);
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // Entered and left at #1 after a rising edge; waited = cycles the command sat unaccepted.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] base, input logic [8:0] len,
                          output int waited);
    bit acc = 1'b0;
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    while (!acc && waited < 1000) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    bus.cmd_valid = 1'b0;
    accept_cyc = cyc - 1;
    if (!acc) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic finish_cmd(input logic [1:0] op, input int len, input int gap_at,
                            input bit rnd_gap, output int lat);
    int k = 0;
    int n = 0;
    bit gapped = 1'b0;
    bit seen = 1'b0;
    lat = -1;
    while (!seen && n < 2000) begin
      if (op == OpLoad && k < len) begin
        if (gap_at == k && !gapped) begin
          bus.in_valid = 1'b0;
          gapped = 1'b1;
        end else begin
          bus.in_valid = !(rnd_gap && $urandom_range(3) == 0);
        end
        bus.in_data = load_bytes[k];
      end else begin
        bus.in_valid = rnd_gap ? 1'($urandom_range(1)) : 1'b0;
        bus.in_data  = 8'($urandom);
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) k++;
      if (bus.done) begin
        seen = 1'b1;
        lat = cyc - accept_cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] base, input logic [8:0] len,
                         input int gap_at, input bit rnd_gap, input int exp_lat,
                         input int exp_wr, input int exp_rd);
    int w, lat, d0, c0, r0, L, a;
    L = int'(len);
    wr_col_q.delete(); wr_din_q.delete(); out_q.delete(); out_cyc_q.delete();
    acc_cyc_q.delete(); acc_rwl_q.delete(); acc_wwl_q.delete();
    first_rd = -1;
    d0 = n_done; c0 = n_clr; r0 = n_rd;
    send_cmd(op, base, len, w);
    finish_cmd(op, L, gap_at, rnd_gap, lat);
    if (exp_lat >= 0) chk("done_latency", lat, exp_lat);
    chk("done_pulses", n_done - d0, 1);
    chk("write_count", wr_col_q.size(), exp_wr);
    chk("read_count", n_rd - r0, exp_rd);
    chk("clr_cycles", n_clr - c0, (op == OpClr) ? 1 : 0);
    if (op == OpLoad) begin
      for (int k = 0; k < L; k++) begin
        a = (int'(base) + k) % 256;
        if (k < wr_col_q.size()) begin
          chk("load_col", int'(wr_col_q[k]), a);
          chk("load_din", int'(wr_din_q[k]), int'(load_bytes[k]));
        end
        ref_mem[a] = load_bytes[k];
      end
    end
    if (op == OpClr) for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    if (op == OpDump) begin
      chk("dump_count", out_q.size(), exp_rd);
      for (int k = 0; k < out_q.size() && k < L; k++)
        chk("dump_data", int'(out_q[k]), int'(ref_mem[(int'(base) + k) % 256]));
      if (out_q.size() > 0) begin
        chk("dump_first_out", out_cyc_q[0] - first_rd, RL + 1);
        chk("dump_contiguous", out_cyc_q[out_cyc_q.size()-1] - out_cyc_q[0], out_q.size() - 1);
      end
    end else begin
      chk("stray_out_valid", out_q.size(), 0);
    end
    if (op == OpAcc) begin
      chk("acc_strobes", acc_cyc_q.size(), 2 * ROWS);
      if (acc_cyc_q.size() == 2 * ROWS) begin
        for (int r = 0; r < ROWS; r++) begin
          chk("acc_rwl", acc_rwl_q[2*r], 1 << r);
          chk("acc_wwl", acc_wwl_q[2*r+1], 1 << r);
          chk("acc_rd_to_wr", acc_cyc_q[2*r+1] - acc_cyc_q[2*r], AL + 1);
        end
      end
    end else begin
      chk("stray_wordline", acc_cyc_q.size(), 0);
    end
  endtask

  task automatic fill_bytes(input int len);
    load_bytes.delete();
    for (int k = 0; k < len; k++) load_bytes.push_back(8'($urandom));
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] base;
    logic [8:0] len;
    int         exp_lat;
    int         exp_wr;
    int         exp_rd;
  } vec_t;

  initial begin : main
    vec_t vecs[11];
    int w, d0, c0, found, lat;
    logic [1:0] op;
    logic [7:0] base;
    logic [8:0] len;

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Latencies count cycles from the handshake cycle to the done cycle (RL=1, AL=1).
    vecs[0]  = '{OpClr,  8'h00, 9'd0,   2,   0,   0};
    vecs[1]  = '{OpLoad, 8'h10, 9'd1,   2,   1,   0};
    vecs[2]  = '{OpLoad, 8'hF0, 9'd5,   6,   5,   0};
    vecs[3]  = '{OpLoad, 8'h00, 9'd0,   1,   0,   0};
    vecs[4]  = '{OpDump, 8'h00, 9'd0,   1,   0,   0};
    vecs[5]  = '{OpDump, 8'h10, 9'd1,   4,   0,   1};
    vecs[6]  = '{OpDump, 8'hF0, 9'd5,   8,   0,   5};
    vecs[7]  = '{OpLoad, 8'h00, 9'd256, 257, 256, 0};
    vecs[8]  = '{OpDump, 8'h80, 9'd256, 259, 0,   256};
    vecs[9]  = '{OpAcc,  8'h00, 9'd0,   25,  0,   0};
    vecs[10] = '{OpDump, 8'hFE, 9'd3,   6,   0,   3};

    #12;
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_mem_lines", int'(|{bus.mem_en, bus.mem_din, bus.mem_col, bus.mem_rwl,
                                bus.mem_wwl, bus.mem_read, bus.mem_write, bus.mem_clr}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].op == OpLoad) fill_bytes(int'(vecs[i].len));
      run_cmd(vecs[i].op, vecs[i].base, vecs[i].len, -1, 1'b0,
              vecs[i].exp_lat, vecs[i].exp_wr, vecs[i].exp_rd);
    end

    // Wrapping LOAD with a one-cycle gap after the second byte, then read it back.
    load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_cmd(OpLoad, 8'hFE, 9'd4, 2, 1'b0, 6, 4, 0);
    run_cmd(OpDump, 8'hFE, 9'd4, -1, 1'b0, 7, 0, 4);

    // A CLEAR held while ACCUM runs is only taken once the sequencer is idle again.
    send_cmd(OpAcc, 8'h00, 9'd0, w);
    c0 = n_clr;
    d0 = n_done;
    send_cmd(OpClr, 8'h00, 9'd0, w);
    chk("held_cmd_wait", w, 25);
    chk("held_cmd_no_clr", n_clr - c0, 0);
    chk("held_cmd_acc_done", n_done - d0, 1);
    finish_cmd(OpClr, 0, -1, 1'b0, lat);
    chk("held_clr_latency", lat, 2);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Asynchronous reset while ACCUM is reading row 3.
    send_cmd(OpAcc, 8'h00, 9'd0, w);
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(negedge clk);
      if (bus.mem_rwl == 8'h08) found = 1;
    end
    chk("acc_row3_reached", found, 1);
    #2;
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_lines", int'(|{bus.mem_en, bus.mem_din, bus.mem_col, bus.mem_rwl,
                                   bus.mem_wwl, bus.mem_read, bus.mem_write, bus.mem_clr}), 0);
    chk("midrst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("midrst_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_no_done", n_done - d0, 0);
    run_cmd(OpClr, 8'h00, 9'd0, -1, 1'b0, 2, 0, 0);
    chk("clr_then_done", done_cyc - clr_cyc, 1);

    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(3));
      base = 8'(8'hF0 + $urandom_range(0, 31));
      len  = ($urandom_range(7) == 0) ? 9'd0 : 9'($urandom_range(1, 20));
      if (op == OpLoad) fill_bytes(int'(len));
      case (op)
        OpClr:   run_cmd(op, base, len, -1, 1'b1, 2, 0, 0);
        OpAcc:   run_cmd(op, base, len, -1, 1'b1, 1 + ROWS * (2 + AL), 0, 0);
        OpLoad:  run_cmd(op, base, len, -1, 1'b1, (len == 0) ? 1 : -1, int'(len), 0);
        default: run_cmd(op, base, len, -1, 1'b1, (len == 0) ? 1 : int'(len) + RL + 2,
                         0, int'(len));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
